ifq_dispatch_reader: RTL and testbench
======================================

Name: ifq_dispatch_reader

Overview:
- Consumer-side front end of the instruction fetch queue; the block that drives inst_rd_en and jmp_branch_address/jmp_branch_valid.
- Pops instructions from the IFQ head into a single-entry issue register with a valid/ready handshake toward the execution back end.
- Decodes J/JAL (redirects at decode) and BEQ/BNE (redirects on external resolution), then sequences the IFQ flush.

Parameters:
- ADDR_W, 32, PC / jump-target width.
- INST_W, 32, instruction width (MIPS-32 encoding).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- inst  in  INST_W  IFQ head instruction; valid when empty=0 (first-word-fall-through).
- pc_out  in  ADDR_W  PC of IFQ head.
- empty  in  1  IFQ empty.
- inst_rd_en  out  1  pop IFQ head at this rising edge.
- jmp_branch_address  out  ADDR_W  redirect target.
- jmp_branch_valid  out  1  one-cycle redirect/flush pulse to the IFQ.
- issue_valid  out  1  issue register holds an instruction.
- issue_ready  in  1  back end accepts this cycle.
- issue_inst  out  INST_W  issued instruction.
- issue_pc  out  ADDR_W  issued PC.
- br_resolve_valid  in  1  branch outcome strobe from execute.
- br_taken  in  1  outcome qualifier.
- stall_br  out  1  high while in WAIT_BR.

Behaviour:
- Reset (async, rst=0): state=RUN; issue_valid=0; jmp_branch_valid=0; jmp_branch_address=0; issue_inst=0; issue_pc=0; stored target=0. inst_rd_en=0 while rst=0. Reset mid-redirect or mid-wait aborts it; no pulse is emitted.
- inst_rd_en is combinational: state==RUN && !empty && (!issue_valid || issue_ready).
- Pop: on the edge with inst_rd_en=1, issue_inst<=inst, issue_pc<=pc_out, issue_valid<=1. Otherwise issue_valid clears when issue_ready=1. Throughput is one instruction per cycle.
- Decode applies to the IFQ head in the pop cycle. Opcode is inst[31:26]: J=000010, JAL=000011, BEQ=000100, BNE=000101.
- Jump target = {pc_plus4[ADDR_W-1:28], inst[25:0], 2'b00}, where pc_plus4 = pc_out+4.
- Branch target = pc_plus4 + (sign-extended inst[15:0] << 2), computed modulo 2^ADDR_W (wraps, no error).
- FSM states RUN, REDIR, WAIT_BR:
  - RUN, popping J/JAL: jmp_branch_address<=target, jmp_branch_valid<=1, go to REDIR. The jump itself is still issued.
  - RUN, popping BEQ/BNE: store target, go to WAIT_BR. The branch is issued.
  - REDIR (exactly 1 cycle): jmp_branch_valid=1, inst_rd_en=0; next state RUN, pulse deasserts. The IFQ flushes on this edge, so empty=1 on the following cycle.
  - WAIT_BR: inst_rd_en=0, stall_br=1. On br_resolve_valid with br_taken=1: load the stored target, pulse jmp_branch_valid, go to REDIR. With br_taken=0: go to RUN, and popping resumes the next cycle.
- br_resolve_valid outside WAIT_BR is ignored.
- A redirect never waits for issue_ready. A held issue entry is kept, not killed.
- Jump/branch delay slots are not modelled. JR/JALR are issued as ordinary instructions.
- jmp_branch_valid is never high for two consecutive cycles.

Decomposition:
- Shared package ifq_pkg:
  - opcode localparams OP_J, OP_JAL, OP_BEQ, OP_BNE.
  - state enum rd_state_t {RUN, REDIR, WAIT_BR}.
  - ADDR_W/INST_W defaults.
- Sub-module ifq_br_decode (combinational): inputs inst, pc; outputs is_jump, is_branch, target.

Test Plan:
- Straight-line code: IFQ holds 4 non-branch instructions at PC 0x00..0x0C, issue_ready=1 → 4 consecutive pops/issues in 4 cycles, issue_pc 0x00,0x04,0x08,0x0C, jmp_branch_valid never set.
- Back-pressure: issue_ready=0 for 3 cycles with the issue register full → inst_rd_en=0 throughout, issue_inst stable. issue_ready=1 → pop resumes the same cycle.
- Jump: J with inst[25:0]=0x0000040 at PC 0x0000_1000 → next cycle jmp_branch_valid=1 for exactly 1 cycle, address 0x0000_0100, inst_rd_en=0 during the pulse.
- Branch taken: BEQ imm=0xFFFF at PC 0x0000_0020 → WAIT_BR, stall_br=1. br_resolve_valid=1, br_taken=1 after 5 cycles → pulse with address 0x0000_0020.
- Branch not taken: BNE imm=0x0004 → WAIT_BR. Resolve with br_taken=0 → no pulse, popping resumes the next cycle at the next PC.
- Reset in WAIT_BR: rst=0 asynchronously mid-wait → all outputs 0 immediately. After rst=1 the state is RUN, and a late br_resolve_valid produces no pulse.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared definitions for the IFQ consumer side: opcodes, reader FSM states
// and default datapath widths.
package ifq_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    REDIR   = 2'd1,
    WAIT_BR = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ifq_br_decode.sv
// Combinational J/JAL/BEQ/BNE classifier and redirect-target generator for
// the instruction at the IFQ head.
module ifq_br_decode
  import ifq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic [INST_W-1:0] inst,
  input  logic [ADDR_W-1:0] pc,
  output logic              is_jump,
  output logic              is_branch,
  output logic [ADDR_W-1:0] target
);

  logic [5:0]        opcode;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_offset;
  logic [ADDR_W-1:0] branch_target;

  always_comb begin
    opcode        = inst[31:26];
    pc_plus4      = pc + ADDR_W'(4);
    jump_target   = {pc_plus4[ADDR_W-1:28], inst[25:0], 2'b00};
    // Word offset, sign-extended; the add wraps modulo 2^ADDR_W.
    branch_offset = {{(ADDR_W-18){inst[15]}}, inst[15:0], 2'b00};
    branch_target = pc_plus4 + branch_offset;
    is_jump       = (opcode == OP_J) || (opcode == OP_JAL);
    is_branch     = (opcode == OP_BEQ) || (opcode == OP_BNE);
    target        = is_jump ? jump_target : branch_target;
  end

endmodule

// File: rtl/ifq_dispatch_reader.sv
// IFQ head reader: pops into a single-entry issue register, redirects on
// jumps at decode and on taken branches after external resolution.
module ifq_dispatch_reader
  import ifq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst,
  input  logic [ADDR_W-1:0] pc_out,
  input  logic              empty,
  output logic              inst_rd_en,
  output logic [ADDR_W-1:0] jmp_branch_address,
  output logic              jmp_branch_valid,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [INST_W-1:0] issue_inst,
  output logic [ADDR_W-1:0] issue_pc,
  input  logic              br_resolve_valid,
  input  logic              br_taken,
  output logic              stall_br
);

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic              pop;
  logic              dec_is_jump;
  logic              dec_is_branch;
  logic [ADDR_W-1:0] dec_target;
  logic [ADDR_W-1:0] br_target_q;
  logic [ADDR_W-1:0] br_target_nxt;
  logic [ADDR_W-1:0] jba_nxt;
  logic              jbv_nxt;

  ifq_br_decode #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_decode (
    .inst      (inst),
    .pc        (pc_out),
    .is_jump   (dec_is_jump),
    .is_branch (dec_is_branch),
    .target    (dec_target)
  );

  assign inst_rd_en = pop;

  // Popping is gated by rst so the IFQ never sees a read strobe during reset.
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    jbv_nxt       = 1'b0;
    jba_nxt       = jmp_branch_address;
    br_target_nxt = br_target_q;
    stall_br      = (state == WAIT_BR);
    case (state)
      RUN: begin
        pop = rst && !empty && (!issue_valid || issue_ready);
        if (pop && dec_is_jump) begin
          jba_nxt   = dec_target;
          jbv_nxt   = 1'b1;
          state_nxt = REDIR;
        end else if (pop && dec_is_branch) begin
          br_target_nxt = dec_target;
          state_nxt     = WAIT_BR;
        end
      end
      REDIR: begin
        state_nxt = RUN;
      end
      WAIT_BR: begin
        if (br_resolve_valid) begin
          if (br_taken) begin
            jba_nxt   = br_target_q;
            jbv_nxt   = 1'b1;
            state_nxt = REDIR;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= RUN;
      jmp_branch_valid   <= 1'b0;
      jmp_branch_address <= '0;
      br_target_q        <= '0;
    end else begin
      state              <= state_nxt;
      jmp_branch_valid   <= jbv_nxt;
      jmp_branch_address <= jba_nxt;
      br_target_q        <= br_target_nxt;
    end
  end

  // A redirect leaves a held issue entry alone; only the back end drains it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid <= 1'b0;
      issue_inst  <= '0;
      issue_pc    <= '0;
    end else if (pop) begin
      issue_valid <= 1'b1;
      issue_inst  <= inst;
      issue_pc    <= pc_out;
    end else if (issue_ready) begin
      issue_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifq_dispatch_reader.sv
// Directed, table-driven bench for ifq_dispatch_reader plus hand-written
// reset-during-branch-wait sequence.
module tb_ifq_dispatch_reader;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic        empty;
  logic        inst_rd_en;
  logic [31:0] jmp_branch_address;
  logic        jmp_branch_valid;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_inst;
  logic [31:0] issue_pc;
  logic        br_resolve_valid;
  logic        br_taken;
  logic        stall_br;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        empty;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        rdy;
    logic        brv;
    logic        brt;
    logic        x_rd;
    logic        x_iv;
    logic [31:0] x_inst;
    logic [31:0] x_pc;
    logic        x_jbv;
    logic [31:0] x_jba;
    logic        x_stall;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] IA   = 32'h0000_1001;
  localparam logic [31:0] IB   = 32'h0000_1002;
  localparam logic [31:0] IC   = 32'h0000_1003;
  localparam logic [31:0] ID   = 32'h0000_1004;
  localparam logic [31:0] IE   = 32'h0000_1005;
  localparam logic [31:0] IF   = 32'h0000_1006;
  localparam logic [31:0] IG   = 32'h0000_2001;
  localparam logic [31:0] IH   = 32'h0000_3001;
  localparam logic [31:0] II   = 32'h0000_4001;
  localparam logic [31:0] JMP  = 32'h0800_0040;
  localparam logic [31:0] BEQ  = 32'h1000_FFFF;
  localparam logic [31:0] BNE  = 32'h1400_0004;
  localparam logic [31:0] BEQW = 32'h1000_0001;
  localparam logic [31:0] JAL  = 32'h0FFF_FFFF;

  ifq_dispatch_reader #(
    .ADDR_W (32),
    .INST_W (32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .inst               (inst),
    .pc_out             (pc_out),
    .empty              (empty),
    .inst_rd_en         (inst_rd_en),
    .jmp_branch_address (jmp_branch_address),
    .jmp_branch_valid   (jmp_branch_valid),
    .issue_valid        (issue_valid),
    .issue_ready        (issue_ready),
    .issue_inst         (issue_inst),
    .issue_pc           (issue_pc),
    .br_resolve_valid   (br_resolve_valid),
    .br_taken           (br_taken),
    .stall_br           (stall_br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic e, input logic [31:0] i, input logic [31:0] p,
                              input logic r, input logic bv, input logic bt,
                              input logic xrd, input logic xiv, input logic [31:0] xi,
                              input logic [31:0] xp, input logic xjv, input logic [31:0] xja,
                              input logic xst);
    vec_t v;
    v.empty = e; v.inst = i; v.pc = p; v.rdy = r; v.brv = bv; v.brt = bt;
    v.x_rd = xrd; v.x_iv = xiv; v.x_inst = xi; v.x_pc = xp;
    v.x_jbv = xjv; v.x_jba = xja; v.x_stall = xst;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    empty            = v.empty;
    inst             = v.inst;
    pc_out           = v.pc;
    issue_ready      = v.rdy;
    br_resolve_valid = v.brv;
    br_taken         = v.brt;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rd_en"},  32'(inst_rd_en), 32'd0);
    checkOutput({tag, " iv"},     32'(issue_valid), 32'd0);
    checkOutput({tag, " jbv"},    32'(jmp_branch_valid), 32'd0);
    checkOutput({tag, " jba"},    jmp_branch_address, 32'd0);
    checkOutput({tag, " iinst"},  issue_inst, 32'd0);
    checkOutput({tag, " ipc"},    issue_pc, 32'd0);
    checkOutput({tag, " stall"},  32'(stall_br), 32'd0);
  endtask

  initial begin
    // Straight-line code
    vecs.push_back(mk(1, IA, 32'h00, 1, 0, 0,  0, 0, 32'h0, 32'h0,   0, 32'h0, 0));
    vecs.push_back(mk(0, IA, 32'h00, 1, 0, 0,  1, 1, IA,    32'h00,  0, 32'h0, 0));
    vecs.push_back(mk(0, IB, 32'h04, 1, 0, 0,  1, 1, IB,    32'h04,  0, 32'h0, 0));
    vecs.push_back(mk(0, IC, 32'h08, 1, 0, 0,  1, 1, IC,    32'h08,  0, 32'h0, 0));
    vecs.push_back(mk(0, ID, 32'h0C, 1, 0, 0,  1, 1, ID,    32'h0C,  0, 32'h0, 0));
    // Back-pressure for three cycles, then pop resumes
    vecs.push_back(mk(0, IE, 32'h10, 0, 0, 0,  0, 1, ID,    32'h0C,  0, 32'h0, 0));
    vecs.push_back(mk(0, IE, 32'h10, 0, 0, 0,  0, 1, ID,    32'h0C,  0, 32'h0, 0));
    vecs.push_back(mk(0, IE, 32'h10, 0, 0, 0,  0, 1, ID,    32'h0C,  0, 32'h0, 0));
    vecs.push_back(mk(0, IE, 32'h10, 1, 0, 0,  1, 1, IE,    32'h10,  0, 32'h0, 0));
    // Jump: J target 0x100, one-cycle pulse, no pop during pulse
    vecs.push_back(mk(0, JMP, 32'h1000, 1, 0, 0, 1, 1, JMP, 32'h1000, 1, 32'h100, 0));
    vecs.push_back(mk(0, IF,  32'h1004, 1, 0, 0, 0, 0, JMP, 32'h1000, 0, 32'h100, 0));
    vecs.push_back(mk(1, IF,  32'h1004, 1, 0, 0, 0, 0, JMP, 32'h1000, 0, 32'h100, 0));
    // Branch taken after a 5-cycle wait, target 0x20
    vecs.push_back(mk(0, BEQ, 32'h20, 1, 0, 0,  1, 1, BEQ, 32'h20, 0, 32'h100, 1));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, IG, 32'h24, 1, 0, 0, 0, 0, BEQ, 32'h20, 0, 32'h100, 1));
    vecs.push_back(mk(0, IG, 32'h24, 1, 1, 1,  0, 0, BEQ, 32'h20, 1, 32'h20, 0));
    vecs.push_back(mk(0, IG, 32'h24, 1, 0, 0,  0, 0, BEQ, 32'h20, 0, 32'h20, 0));
    // Branch not taken: resume popping next cycle
    vecs.push_back(mk(0, BNE, 32'h40, 1, 0, 0,  1, 1, BNE, 32'h40, 0, 32'h20, 1));
    vecs.push_back(mk(0, IH,  32'h44, 1, 1, 0,  0, 0, BNE, 32'h40, 0, 32'h20, 0));
    vecs.push_back(mk(0, IH,  32'h44, 1, 0, 0,  1, 1, IH,  32'h44, 0, 32'h20, 0));
    // Resolve strobe outside WAIT_BR is ignored
    vecs.push_back(mk(0, II,  32'h48, 1, 1, 1,  1, 1, II,  32'h48, 0, 32'h20, 0));
    // Branch target wraps past 2^32
    vecs.push_back(mk(0, BEQW, 32'hFFFF_FFF8, 1, 0, 0, 1, 1, BEQW, 32'hFFFF_FFF8, 0, 32'h20, 1));
    vecs.push_back(mk(1, II,   32'h0,         1, 1, 1, 0, 0, BEQW, 32'hFFFF_FFF8, 1, 32'h0,  0));
    vecs.push_back(mk(1, II,   32'h0,         1, 0, 0, 0, 0, BEQW, 32'hFFFF_FFF8, 0, 32'h0,  0));
    // JAL keeps upper PC nibble of pc+4
    vecs.push_back(mk(0, JAL, 32'hA000_0000, 1, 0, 0, 1, 1, JAL, 32'hA000_0000, 1, 32'hAFFF_FFFC, 0));
    vecs.push_back(mk(1, II,  32'h0,         1, 0, 0, 0, 0, JAL, 32'hA000_0000, 0, 32'hAFFF_FFFC, 0));

    // Reset state, with a valid head presented to prove rd_en stays low
    rst = 1'b0;
    empty = 1'b0; inst = IA; pc_out = 32'h0; issue_ready = 1'b1;
    br_resolve_valid = 1'b0; br_taken = 1'b0;
    #3;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < vecs.size(); n++) begin
      applyStimulus(vecs[n]);
      #1;
      checkOutput($sformatf("v%0d rd_en", n), 32'(inst_rd_en), 32'(vecs[n].x_rd));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d iv", n),    32'(issue_valid), 32'(vecs[n].x_iv));
      checkOutput($sformatf("v%0d iinst", n), issue_inst, vecs[n].x_inst);
      checkOutput($sformatf("v%0d ipc", n),   issue_pc, vecs[n].x_pc);
      checkOutput($sformatf("v%0d jbv", n),   32'(jmp_branch_valid), 32'(vecs[n].x_jbv));
      checkOutput($sformatf("v%0d jba", n),   jmp_branch_address, vecs[n].x_jba);
      checkOutput($sformatf("v%0d stall", n), 32'(stall_br), 32'(vecs[n].x_stall));
      @(negedge clk);
    end

    // Reset asserted asynchronously while waiting on a branch
    empty = 1'b0; inst = BEQ; pc_out = 32'h20; issue_ready = 1'b0;
    br_resolve_valid = 1'b0; br_taken = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rw stall_before", 32'(stall_br), 32'd1);
    @(negedge clk);
    empty = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("rw async");
    @(negedge clk);
    rst = 1'b1;
    br_resolve_valid = 1'b1; br_taken = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rw late_jbv", 32'(jmp_branch_valid), 32'd0);
    checkOutput("rw late_stall", 32'(stall_br), 32'd0);
    @(negedge clk);
    br_resolve_valid = 1'b0; br_taken = 1'b0;
    empty = 1'b0; inst = IH; pc_out = 32'h44; issue_ready = 1'b1;
    #1;
    checkOutput("rw resume_rd", 32'(inst_rd_en), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("rw resume_jbv", 32'(jmp_branch_valid), 32'd0);
    checkOutput("rw resume_ipc", issue_pc, 32'h44);
    checkOutput("rw resume_iv", 32'(issue_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
